// File: rtl/vpe_bias_seq.sv
// Sequencer/arbiter feeding the VPE bias adder: round-robin between two activation
// requesters, bias RAM fetch (1-cycle read latency), and 2-stage alignment of data, bias and tags.
module vpe_bias_seq #(
  parameter int BIAS_AW = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cfg_v,
  input  logic [BIAS_AW-1:0] i_cfg_base,
  input  logic [CNT_W-1:0]   i_cfg_len,
  input  logic               i_cfg_relu,
  input  logic [4:0]         i_cfg_rf_idx_base,
  input  logic [1:0]         i_cfg_rf_mux,
  input  logic [63:0]        i_req0_data,
  input  logic               i_req0_v,
  output logic               o_req0_rdy,
  input  logic [63:0]        i_req1_data,
  input  logic               i_req1_v,
  output logic               o_req1_rdy,
  output logic               o_bias_ren,
  output logic [BIAS_AW-1:0] o_bias_raddr,
  input  logic [63:0]        i_bias_rdata,
  output logic [63:0]        o_add_data,
  output logic [63:0]        o_add_bias,
  output logic               o_add_data_v,
  output logic               o_en_relu,
  output logic [4:0]         o_rf_idx,
  output logic [1:0]         o_rf_mux,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic               rr_q, rr_d;
  logic [BIAS_AW-1:0] base_q;
  logic [CNT_W-1:0]   len_q;
  logic               relu_q;
  logic [4:0]         rfb_q;
  logic [1:0]         mux_q;
  logic               cfg_load;
  logic               gnt0, gnt1, accept;
  logic [63:0]        acc_data;

  logic               vld_p1_q;
  logic [63:0]        data_p1_q;
  logic [4:0]         rf_p1_q;

  logic               vld_p2_q;
  logic [63:0]        data_p2_q, bias_p2_q;
  logic [4:0]         rf_p2_q;
  logic               relu_p2_q;
  logic [1:0]         mux_p2_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    rr_d     = rr_q;
    cfg_load = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    o_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cfg_v && (i_cfg_len != '0)) begin
          cfg_load = 1'b1;
          k_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // rr only breaks ties; a lone valid requester always wins
        if (i_req0_v && (!i_req1_v || !rr_q)) gnt0 = 1'b1;
        else if (i_req1_v)                     gnt1 = 1'b1;
        if (gnt0 || gnt1) begin
          k_d  = k_q + CNT_W'(1);
          rr_d = gnt0;
          if (k_q == len_q - CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!vld_p1_q && !vld_p2_q) begin
          o_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept       = gnt0 | gnt1;
  assign acc_data     = gnt1 ? i_req1_data : i_req0_data;
  assign o_req0_rdy   = gnt0;
  assign o_req1_rdy   = gnt1;
  assign o_bias_ren   = accept;
  assign o_bias_raddr = base_q + BIAS_AW'(k_q);
  assign o_busy       = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      rr_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      relu_q   <= 1'b0;
      rfb_q    <= '0;
      mux_q    <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      rr_q     <= rr_d;
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
      if (cfg_load) begin
        base_q <= i_cfg_base;
        len_q  <= i_cfg_len;
        relu_q <= i_cfg_relu;
        rfb_q  <= i_cfg_rf_idx_base;
        mux_q  <= i_cfg_rf_mux;
      end
    end
  end

  // ---- stage 1: granted activation + rf_idx, bias read in flight ----
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1_q <= acc_data;
      rf_p1_q   <= rfb_q + 5'(k_q);
    end
  end

  // ---- stage 2: join with bias RAM data; pass-wide tags are stable until the pass drains ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2_q <= '0;
      bias_p2_q <= '0;
      rf_p2_q   <= '0;
      relu_p2_q <= 1'b0;
      mux_p2_q  <= '0;
    end else if (vld_p1_q) begin
      data_p2_q <= data_p1_q;
      bias_p2_q <= i_bias_rdata;
      rf_p2_q   <= rf_p1_q;
      relu_p2_q <= relu_q;
      mux_p2_q  <= mux_q;
    end
  end

  assign o_add_data_v = vld_p2_q;
  assign o_add_data   = data_p2_q;
  assign o_add_bias   = bias_p2_q;
  assign o_rf_idx     = rf_p2_q;
  assign o_en_relu    = relu_p2_q;
  assign o_rf_mux     = mux_p2_q;

endmodule

// File: tb/tb_vpe_bias_seq.sv
// Directed bench for vpe_bias_seq: bias RAM model, event logger, one task per scenario.
module tb_vpe_bias_seq;

  localparam logic [63:0] A_BASE = 64'hA0A1_A2A3_0000_0000;
  localparam logic [63:0] B_BASE = 64'hB0B1_B2B3_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cfg_v = 1'b0;
  logic [7:0]  i_cfg_base = '0;
  logic [7:0]  i_cfg_len = '0;
  logic        i_cfg_relu = 1'b0;
  logic [4:0]  i_cfg_rf_idx_base = '0;
  logic [1:0]  i_cfg_rf_mux = '0;
  logic [63:0] i_req0_data = '0;
  logic        i_req0_v = 1'b0;
  logic        o_req0_rdy;
  logic [63:0] i_req1_data = '0;
  logic        i_req1_v = 1'b0;
  logic        o_req1_rdy;
  logic        o_bias_ren;
  logic [7:0]  o_bias_raddr;
  logic [63:0] i_bias_rdata = '0;
  logic [63:0] o_add_data, o_add_bias;
  logic        o_add_data_v, o_en_relu, o_busy, o_done;
  logic [4:0]  o_rf_idx;
  logic [1:0]  o_rf_mux;

  always #5 clk = ~clk;

  vpe_bias_seq #(.BIAS_AW(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_cfg_v(i_cfg_v), .i_cfg_base(i_cfg_base), .i_cfg_len(i_cfg_len),
    .i_cfg_relu(i_cfg_relu), .i_cfg_rf_idx_base(i_cfg_rf_idx_base), .i_cfg_rf_mux(i_cfg_rf_mux),
    .i_req0_data(i_req0_data), .i_req0_v(i_req0_v), .o_req0_rdy(o_req0_rdy),
    .i_req1_data(i_req1_data), .i_req1_v(i_req1_v), .o_req1_rdy(o_req1_rdy),
    .o_bias_ren(o_bias_ren), .o_bias_raddr(o_bias_raddr), .i_bias_rdata(i_bias_rdata),
    .o_add_data(o_add_data), .o_add_bias(o_add_bias), .o_add_data_v(o_add_data_v),
    .o_en_relu(o_en_relu), .o_rf_idx(o_rf_idx), .o_rf_mux(o_rf_mux),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Distinct word per address (top byte is the address itself)
  function automatic logic [63:0] ram_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3, a + 8'd1, 8'h3C, ~(a ^ 8'h0F), a ^ 8'hA5};
  endfunction

  always_ff @(posedge clk) begin
    if (o_bias_ren) i_bias_rdata <= ram_word(o_bias_raddr);
  end

  typedef struct { int cyc; int idx; logic [7:0] addr; logic ren; logic [63:0] data; } acc_t;
  typedef struct { int cyc; logic [63:0] data; logic [63:0] bias; logic [4:0] rf; logic relu; logic [1:0] mux; } out_t;

  acc_t accq[$];
  out_t outq[$];
  int   doneq[$];
  int   both_rdy = 0;
  int   cyc_n = 0;
  int   errors = 0;
  int   checks = 0;
  acc_t mon_a;
  out_t mon_o;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_req0_rdy && o_req1_rdy) both_rdy = both_rdy + 1;
      if ((i_req0_v && o_req0_rdy) || (i_req1_v && o_req1_rdy)) begin
        mon_a.cyc  = cyc_n;
        mon_a.idx  = (i_req1_v && o_req1_rdy) ? 1 : 0;
        mon_a.addr = o_bias_raddr;
        mon_a.ren  = o_bias_ren;
        mon_a.data = (i_req1_v && o_req1_rdy) ? i_req1_data : i_req0_data;
        accq.push_back(mon_a);
      end
      if (o_add_data_v) begin
        mon_o.cyc  = cyc_n;
        mon_o.data = o_add_data;
        mon_o.bias = o_add_bias;
        mon_o.rf   = o_rf_idx;
        mon_o.relu = o_en_relu;
        mon_o.mux  = o_rf_mux;
        outq.push_back(mon_o);
      end
      if (o_done) doneq.push_back(cyc_n);
    end
  end

  task automatic clear_logs();
    accq.delete();
    outq.delete();
    doneq.delete();
    both_rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic do_cfg(input logic [7:0] b, input logic [7:0] l, input logic r,
                        input logic [4:0] rf, input logic [1:0] m);
    i_cfg_base = b; i_cfg_len = l; i_cfg_relu = r; i_cfg_rf_idx_base = rf; i_cfg_rf_mux = m;
    i_cfg_v = 1'b1;
    @(posedge clk); #1;
    i_cfg_v = 1'b0;
  endtask

  // Requesters hold valid/data until granted; stops once o_done has been logged
  task automatic stream(input int n0, input int n1, input bit gap, input int maxc, output bit timeout);
    int s0, s1, c, nd;
    s0 = 0; s1 = 0; c = 0;
    nd = doneq.size();
    timeout = 1'b1;
    while (c < maxc) begin
      i_req0_v    = (s0 < n0) && (!gap || (c % 2 == 0));
      i_req0_data = A_BASE | 64'(s0);
      i_req1_v    = (s1 < n1) && (!gap || (c % 2 == 0));
      i_req1_data = B_BASE | 64'(s1);
      #1;
      if (i_req0_v && o_req0_rdy) s0++;
      if (i_req1_v && o_req1_rdy) s1++;
      @(posedge clk); #1;
      i_cfg_v = 1'b0;
      c++;
      if (doneq.size() > nd) begin
        timeout = 1'b0;
        break;
      end
    end
    i_req0_v = 1'b0;
    i_req1_v = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req0_v = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++; if (o_add_data_v !== 1'b0 || o_add_data !== 64'd0 || o_add_bias !== 64'd0) begin
      errors++; $display("FAIL reset_add: v=%b data=%h bias=%h, want all 0", o_add_data_v, o_add_data, o_add_bias); end
    checks++; if (o_en_relu !== 1'b0 || o_rf_idx !== 5'd0 || o_rf_mux !== 2'd0) begin
      errors++; $display("FAIL reset_tags: relu=%b rf=%0d mux=%0d, want 0", o_en_relu, o_rf_idx, o_rf_mux); end
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b, want 0", o_busy, o_done); end
    checks++; if (o_req0_rdy !== 1'b0 || o_req1_rdy !== 1'b0 || o_bias_ren !== 1'b0) begin
      errors++; $display("FAIL reset_idle_rdy: rdy0=%b rdy1=%b ren=%b, want 0", o_req0_rdy, o_req1_rdy, o_bias_ren); end
    i_req0_v = 1'b0;
    clear_logs();
  endtask

  task automatic test_basic();
    bit to;
    logic [7:0] ea [3] = '{8'h10, 8'h11, 8'h12};
    logic [4:0] er [3] = '{5'd4, 5'd5, 5'd6};
    clear_logs();
    do_cfg(8'h10, 8'd3, 1'b1, 5'd4, 2'd2);
    stream(3, 0, 1'b0, 40, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: no o_done within 40 cycles"); end
    checks++;
    if (accq.size() != 3 || outq.size() != 3) begin
      errors++; $display("FAIL basic_counts: accepts=%0d outputs=%0d, want 3/3", accq.size(), outq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (accq[i].addr !== ea[i] || accq[i].ren !== 1'b1 || accq[i].idx != 0) begin
          errors++; $display("FAIL basic_raddr[%0d]: addr=%h ren=%b req=%0d, want %h/1/0", i, accq[i].addr, accq[i].ren, accq[i].idx, ea[i]); end
        checks++; if (accq[i].cyc != accq[0].cyc + i) begin
          errors++; $display("FAIL basic_b2b[%0d]: accept cycle %0d, want %0d", i, accq[i].cyc, accq[0].cyc + i); end
        checks++; if (outq[i].cyc != accq[0].cyc + 2 + i) begin
          errors++; $display("FAIL basic_latency[%0d]: valid cycle %0d, want %0d", i, outq[i].cyc, accq[0].cyc + 2 + i); end
        checks++; if (outq[i].data !== (A_BASE | 64'(i)) || outq[i].bias !== ram_word(ea[i])) begin
          errors++; $display("FAIL basic_data[%0d]: data=%h bias=%h, want %h/%h", i, outq[i].data, outq[i].bias, A_BASE | 64'(i), ram_word(ea[i])); end
        checks++; if (outq[i].rf !== er[i] || outq[i].relu !== 1'b1 || outq[i].mux !== 2'd2) begin
          errors++; $display("FAIL basic_tags[%0d]: rf=%0d relu=%b mux=%0d, want %0d/1/2", i, outq[i].rf, outq[i].relu, outq[i].mux, er[i]); end
      end
      checks++; if (doneq.size() != 1 || doneq[0] != accq[0].cyc + 5) begin
        errors++; $display("FAIL basic_done: count=%0d cycle=%0d, want 1 at %0d", doneq.size(), (doneq.size() > 0) ? doneq[0] : -1, accq[0].cyc + 5); end
    end
    checks++; if (o_add_data_v !== 1'b0 || o_add_data !== (A_BASE | 64'd2) || o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_hold: v=%b data=%h busy=%b, want 0/%h/0", o_add_data_v, o_add_data, o_busy, A_BASE | 64'd2); end
  endtask

  task automatic test_rr();
    bit to;
    int         eidx [4] = '{0, 1, 0, 1};
    logic [63:0] ed  [4] = '{A_BASE, B_BASE, A_BASE | 64'd1, B_BASE | 64'd1};
    do_reset();
    do_cfg(8'h20, 8'd4, 1'b0, 5'd0, 2'd1);
    stream(4, 4, 1'b0, 40, to);
    checks++; if (to) begin errors++; $display("FAIL rr_timeout: no o_done within 40 cycles"); end
    checks++; if (both_rdy != 0) begin errors++; $display("FAIL rr_onehot: both rdy high in %0d cycles, want 0", both_rdy); end
    checks++;
    if (accq.size() != 4 || outq.size() != 4) begin
      errors++; $display("FAIL rr_counts: accepts=%0d outputs=%0d, want 4/4", accq.size(), outq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (accq[i].idx != eidx[i] || outq[i].data !== ed[i]) begin
          errors++; $display("FAIL rr_order[%0d]: req=%0d data=%h, want %0d/%h", i, accq[i].idx, outq[i].data, eidx[i], ed[i]); end
        checks++; if (outq[i].rf !== 5'(i) || outq[i].relu !== 1'b0 || outq[i].mux !== 2'd1) begin
          errors++; $display("FAIL rr_tags[%0d]: rf=%0d relu=%b mux=%0d, want %0d/0/1", i, outq[i].rf, outq[i].relu, outq[i].mux, i); end
      end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [7:0] ea [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [4:0] er [3] = '{5'd31, 5'd0, 5'd1};
    clear_logs();
    do_cfg(8'hFE, 8'd3, 1'b0, 5'd31, 2'd3);
    stream(0, 3, 1'b0, 40, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout: no o_done within 40 cycles"); end
    checks++;
    if (accq.size() != 3 || outq.size() != 3) begin
      errors++; $display("FAIL wrap_counts: accepts=%0d outputs=%0d, want 3/3", accq.size(), outq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (accq[i].addr !== ea[i] || accq[i].idx != 1) begin
          errors++; $display("FAIL wrap_raddr[%0d]: addr=%h req=%0d, want %h/1", i, accq[i].addr, accq[i].idx, ea[i]); end
        checks++; if (outq[i].rf !== er[i] || outq[i].bias !== ram_word(ea[i]) || outq[i].data !== (B_BASE | 64'(i))) begin
          errors++; $display("FAIL wrap_out[%0d]: rf=%0d bias=%h data=%h, want %0d/%h/%h", i, outq[i].rf, outq[i].bias, outq[i].data, er[i], ram_word(ea[i]), B_BASE | 64'(i)); end
      end
    end
  endtask

  task automatic test_gap();
    bit to;
    clear_logs();
    do_cfg(8'h40, 8'd2, 1'b1, 5'd10, 2'd1);
    stream(2, 0, 1'b1, 40, to);
    checks++; if (to) begin errors++; $display("FAIL gap_timeout: no o_done within 40 cycles"); end
    checks++;
    if (accq.size() != 2 || outq.size() != 2 || doneq.size() != 1) begin
      errors++; $display("FAIL gap_counts: accepts=%0d outputs=%0d dones=%0d, want 2/2/1", accq.size(), outq.size(), doneq.size());
    end else begin
      checks++; if (outq[0].cyc != accq[0].cyc + 2 || outq[1].cyc != outq[0].cyc + 2) begin
        errors++; $display("FAIL gap_timing: valids at %0d,%0d, want %0d,%0d", outq[0].cyc, outq[1].cyc, accq[0].cyc + 2, accq[0].cyc + 4); end
      checks++; if (outq[0].bias !== ram_word(8'h40) || outq[1].bias !== ram_word(8'h41)) begin
        errors++; $display("FAIL gap_bias: %h,%h, want %h,%h", outq[0].bias, outq[1].bias, ram_word(8'h40), ram_word(8'h41)); end
      checks++; if (outq[0].rf !== 5'd10 || outq[1].rf !== 5'd11 || doneq[0] != outq[1].cyc + 1) begin
        errors++; $display("FAIL gap_tail: rf=%0d,%0d done=%0d, want 10,11 done=%0d", outq[0].rf, outq[1].rf, doneq[0], outq[1].cyc + 1); end
    end
  endtask

  task automatic test_cfg_ignore();
    bit to;
    clear_logs();
    i_cfg_base = 8'h33; i_cfg_len = 8'd0; i_cfg_v = 1'b1;
    i_req0_v = 1'b1; i_req0_data = A_BASE;
    @(posedge clk); #1;
    i_cfg_v = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_req0_rdy !== 1'b0) begin
      errors++; $display("FAIL len0_idle: busy=%b rdy0=%b, want 0/0", o_busy, o_req0_rdy); end
    repeat (3) begin @(posedge clk); #1; end
    i_req0_v = 1'b0;
    checks++; if (doneq.size() != 0 || accq.size() != 0) begin
      errors++; $display("FAIL len0_quiet: dones=%0d accepts=%0d, want 0/0", doneq.size(), accq.size()); end
    clear_logs();
    do_cfg(8'h50, 8'd2, 1'b0, 5'd0, 2'd0);
    i_cfg_base = 8'h90; i_cfg_len = 8'd5; i_cfg_v = 1'b1;
    stream(4, 0, 1'b0, 40, to);
    checks++; if (to) begin errors++; $display("FAIL runcfg_timeout: no o_done within 40 cycles"); end
    checks++;
    if (accq.size() != 2) begin
      errors++; $display("FAIL runcfg_len: accepts=%0d, want 2", accq.size());
    end else begin
      checks++; if (accq[0].addr !== 8'h50 || accq[1].addr !== 8'h51) begin
        errors++; $display("FAIL runcfg_base: addr=%h,%h, want 50,51", accq[0].addr, accq[1].addr); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_logs();
    do_cfg(8'h60, 8'd3, 1'b1, 5'd7, 2'd2);
    i_req0_v = 1'b1; i_req0_data = 64'hDEAD_BEEF_0000_0001;
    #1;
    checks++; if (o_req0_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_grant: rdy0=%b, want 1", o_req0_rdy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_req0_rdy !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: busy=%b done=%b rdy0=%b, want 0", o_busy, o_done, o_req0_rdy); end
    checks++; if (o_add_data_v !== 1'b0 || o_add_data !== 64'd0 || o_add_bias !== 64'd0 ||
                  o_rf_idx !== 5'd0 || o_en_relu !== 1'b0 || o_rf_mux !== 2'd0) begin
      errors++; $display("FAIL rstmid_outs: v=%b data=%h bias=%h rf=%0d relu=%b mux=%0d, want 0", o_add_data_v, o_add_data, o_add_bias, o_rf_idx, o_en_relu, o_rf_mux); end
    i_req0_v = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (doneq.size() != 0 || outq.size() != 0) begin
      errors++; $display("FAIL rstmid_abandon: dones=%0d outputs=%0d, want 0/0", doneq.size(), outq.size()); end
    clear_logs();
    do_cfg(8'h70, 8'd2, 1'b0, 5'd3, 2'd0);
    stream(2, 0, 1'b0, 40, to);
    checks++; if (to || doneq.size() != 1) begin
      errors++; $display("FAIL rstmid_rerun_done: timeout=%b dones=%0d, want 0/1", to, doneq.size()); end
    checks++;
    if (accq.size() != 2 || outq.size() != 2) begin
      errors++; $display("FAIL rstmid_rerun_counts: accepts=%0d outputs=%0d, want 2/2", accq.size(), outq.size());
    end else begin
      checks++; if (accq[0].addr !== 8'h70 || accq[1].addr !== 8'h71 || outq[0].rf !== 5'd3 || outq[1].rf !== 5'd4) begin
        errors++; $display("FAIL rstmid_rerun_k0: addr=%h,%h rf=%0d,%0d, want 70,71 rf=3,4", accq[0].addr, accq[1].addr, outq[0].rf, outq[1].rf); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rr();
    test_wrap();
    test_gap();
    test_cfg_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vpe_bias_seq.md
Name: vpe_bias_seq

Overview:
- Sequencer and arbiter in front of the VPE bias adder; the adder always accepts input.
- Shares the adder between two activation requesters with round-robin arbitration.
- For each accepted 1x8 int8 activation vector, fetches the matching bias vector from the bias RAM, which has 1-cycle read latency.
- Presents activation, bias and the per-vector pipeline tags (relu enable, rf_idx, rf_mux) aligned to the adder, and signals completion of each configured pass.

Parameters:
BIAS_AW, 8, bias RAM address width
CNT_W, 8, width of the vectors-per-pass counter

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
i_cfg_v  input  1  pass configuration strobe; sampled only in IDLE
i_cfg_base  input  BIAS_AW  bias RAM address of vector 0 of the pass
i_cfg_len  input  CNT_W  number of vectors in the pass; 0 is illegal
i_cfg_relu  input  1  relu/saturate enable for the whole pass
i_cfg_rf_idx_base  input  5  rf_idx of vector 0 of the pass
i_cfg_rf_mux  input  2  rf_mux for the whole pass
i_req0_data  input  64  requester 0 activation vector
i_req0_v  input  1  requester 0 valid
o_req0_rdy  output  1  requester 0 grant/ready
i_req1_data  input  64  requester 1 activation vector
i_req1_v  input  1  requester 1 valid
o_req1_rdy  output  1  requester 1 grant/ready
o_bias_ren  output  1  bias RAM read enable
o_bias_raddr  output  BIAS_AW  bias RAM read address
i_bias_rdata  input  64  bias RAM data, valid the cycle after o_bias_ren
o_add_data  output  64  activation vector to the adder
o_add_bias  output  64  bias vector to the adder
o_add_data_v  output  1  adder input valid
o_en_relu  output  1  relu tag for the adder
o_rf_idx  output  5  rf index tag for the adder
o_rf_mux  output  2  rf mux tag for the adder
o_busy  output  1  high in RUN or DRAIN
o_done  output  1  1-cycle pulse when a pass has fully left the pipeline

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; counter k=0; round-robin pointer rr=0; both pipeline valids are cleared.
  - All o_add_* outputs, o_en_relu, o_rf_idx, o_rf_mux, o_busy and o_done go to 0.
  - Reset mid-pass abandons the pass with no o_done. Bias read data arriving after reset is ignored.
- IDLE:
  - rdy0 = rdy1 = 0.
  - i_cfg_v=1 with i_cfg_len!=0: latch base, len, relu, rf_idx_base and rf_mux; k=0; go to RUN.
  - i_cfg_v=1 with i_cfg_len==0: ignored; stay in IDLE with no o_done.
- Configuration strobes in RUN or DRAIN are ignored.
- RUN, arbitration (combinational from valids, state and rr):
  - Exactly one requester is valid: that requester is granted.
  - Both are valid: requester rr is granted.
  - rdyN = grantN. At most one rdy is high per cycle.
- Accept = valid & rdy for either requester. In an accept cycle:
  - o_bias_ren=1 and o_bias_raddr = (base + k) mod 2^BIAS_AW, both combinational. The address wraps silently.
  - At the edge: stage-1 captures the granted data and rf_idx = (rf_idx_base + k) mod 32; s1_v=1; k increments.
  - rr = 1 - (granted index).
- Last accept (k == len-1): go to DRAIN at the same edge. No further grants in that cycle or after.
- Pipeline timing, for an accept in cycle T:
  - Stage-2 registers are loaded at the end of cycle T+1, from stage-1 and i_bias_rdata.
  - o_add_data_v=1 in cycle T+2, with o_add_data, o_add_bias, o_rf_idx, o_en_relu and o_rf_mux valid in that same cycle.
  - Fixed latency is 2 cycles. Back-to-back accepts give back-to-back valids.
- When no vector is presented, o_add_data_v=0 and the data/tag outputs hold their previous values.
- DRAIN:
  - Wait until s1_v=0 and the stage-2 valid has been emitted.
  - Pulse o_done for 1 cycle, the cycle after the last o_add_data_v. Go to IDLE on the same edge.
  - A new i_cfg_v can be accepted the cycle after o_done.
- Output packing: o_add_data is the requester data unmodified. No byte reordering is done here.
- Requester protocol: a requester holds valid and data stable until its rdy is seen. The rdy signals combinationally depend on the valids.

Test Plan:
- Reset → all outputs 0. Config base=0x10, len=3, relu=1, rf_idx_base=4, rf_mux=2. Req0 streams vectors A, B, C back-to-back → raddr 0x10, 0x11, 0x12 in the accept cycles; o_add_data_v in cycles T+2..T+4 with rf_idx 4, 5, 6, relu=1, mux=2; o_done in cycle T+5.
- Both requesters continuously valid, len=4 → grant order 0, 1, 0, 1; rdy never high for both at once; rdy0/rdy1 drop after the 4th accept.
- base=0xFE, len=3 → raddr 0xFE, 0xFF, 0x00. rf_idx_base=31, len=2 → rf_idx 31, 0.
- Gapped traffic, valid on alternate cycles, len=2 → o_add_data_v on alternate cycles. o_add_bias equals the RAM content at each issued address (RAM returns distinct words per address).
- i_cfg_len=0 in IDLE → stays IDLE, no rdy, no o_done. i_cfg_v pulsed in RUN → ignored; latched len unchanged.
- Assert rst during RUN after 1 of 3 accepts → next cycle IDLE, all outputs 0, no o_done. A fresh config then runs normally from k=0.
